// File: rtl/regs_mem_2r1w.sv
// Two-read, one-write register file for the picoMIPS datapath.
// A hard-wired zero register, plus a hardware init sweep that loads the unity register.
module regs_mem_2r1w #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 8,
  parameter int              ADDR_W    = $clog2(DEPTH),
  parameter int              ZERO_ADDR = 0,
  parameter int              U_ADDR    = 1,
  parameter logic [WIDTH-1:0] U_VAL    = WIDTH'(1),
  parameter bit              BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  qa,
  output logic [WIDTH-1:0]  qb,
  output logic              ready
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_ADDR);
  localparam logic [ADDR_W-1:0] U_A     = ADDR_W'(U_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [WIDTH-1:0]  port_data;
  logic [WIDTH-1:0]  val_a;
  logic [WIDTH-1:0]  val_b;

  // Non-power-of-two depths leave holes in the address space.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_X;
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // The init sweep and run-time writes share the single RAM write port.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    port_we    = 1'b0;
    port_addr  = wr_addr;
    port_data  = d;
    case (state)
      INIT: begin
        port_we   = 1'b1;
        port_addr = cnt;
        port_data = (cnt == U_A) ? U_VAL : '0;
        if (cnt == LAST_A) begin
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RUN: begin
        port_we = we && in_range(wr_addr) && (wr_addr != ZERO_A);
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (port_we) begin
      mem[port_addr] <= port_data;
    end
  end

  always_comb begin
    val_a = '0;
    if (in_range(rd_addr_a) && (rd_addr_a != ZERO_A)) begin
      if (BYPASS && we && (wr_addr == rd_addr_a)) begin
        val_a = d;
      end else begin
        val_a = mem[rd_addr_a];
      end
    end
  end

  always_comb begin
    val_b = '0;
    if (in_range(rd_addr_b) && (rd_addr_b != ZERO_A)) begin
      if (BYPASS && we && (wr_addr == rd_addr_b)) begin
        val_b = d;
      end else begin
        val_b = mem[rd_addr_b];
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      qa <= '0;
      qb <= '0;
    end else if (state == RUN) begin
      qa <= val_a;
      qb <= val_b;
    end else begin
      qa <= '0;
      qb <= '0;
    end
  end

  assign ready = (state == RUN);

endmodule
